// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for a 64-bit RISC-V datapath.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB.
// Instruction fetch and data access share one handshaked memory port.
// Strobes are decoded from the registered state, the latched instruction
// class and mem_ready. The block also detects faults and counts retired
// instructions.
module mc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             alu_invalid,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             ir_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic [2:0]       state_out,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired_count
);

    localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE    = 3'd0,
        CL_R       = 3'd1,
        CL_IALU    = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_JALR    = 3'd5,
        CL_SYS     = 3'd6,
        CL_ILLEGAL = 3'd7
    } iclass_t;

    // Map a major opcode onto the instruction classes the sequencer understands.
    function automatic iclass_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: return CL_R;
            7'b0010011: return CL_IALU;
            7'b0000011: return CL_LOAD;
            7'b0100011: return CL_STORE;
            7'b1100111: return CL_JALR;
            7'b1110011: return CL_SYS;
            default:    return CL_ILLEGAL;
        endcase
    endfunction

    state_t             state_q;
    iclass_t            class_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [CNT_W-1:0]   retired_q;
    logic               fault_q;
    logic [1:0]         code_q;

    logic               waiting;
    logic               timed_out;
    logic               retire;
    iclass_t            dec_class;

    // A wait state times out on the last allowed cycle only if memory is
    // still not ready. A ready on that same cycle completes normally.
    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timed_out = waiting && !mem_ready && (tmo_q == TMO_LAST);
    assign retire    = (state_q == S_WB) ||
                       ((state_q == S_MEM) && mem_ready && (class_q == CL_STORE));
    assign dec_class = classify(opcode);

    // Sequencer state, class latch, wait-timeout counter, fault record and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            class_q   <= CL_NONE;
            tmo_q     <= '0;
            retired_q <= '0;
            fault_q   <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        state_q <= S_DECODE;
                    end else if (timed_out) begin
                        state_q <= S_HALT;
                        fault_q <= 1'b1;
                        code_q  <= 2'd1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_DECODE: begin
                    class_q <= dec_class;
                    case (dec_class)
                        CL_SYS: begin
                            state_q <= S_HALT;
                            fault_q <= 1'b0;
                            code_q  <= 2'd0;
                        end
                        CL_ILLEGAL: begin
                            state_q <= S_HALT;
                            fault_q <= 1'b1;
                            code_q  <= 2'd2;
                        end
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if (alu_invalid) begin
                        state_q <= S_HALT;
                        fault_q <= 1'b1;
                        code_q  <= 2'd3;
                    end else if ((class_q == CL_LOAD) || (class_q == CL_STORE)) begin
                        state_q <= S_MEM;
                        tmo_q   <= '0;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (class_q == CL_STORE) begin
                            state_q <= S_FETCH;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= S_WB;
                        end
                    end else if (timed_out) begin
                        state_q <= S_HALT;
                        fault_q <= 1'b1;
                        code_q  <= 2'd1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                end
                S_HALT: state_q <= S_HALT;
                default: begin
                    state_q <= S_FETCH;
                    tmo_q   <= '0;
                end
            endcase
        end
    end

    // Strobe and select decode. Reset forces every output of this decode low.
    always_comb begin
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        if (!rst) begin
            if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
                alu_src = (class_q == CL_IALU) || (class_q == CL_LOAD) ||
                          (class_q == CL_STORE) || (class_q == CL_JALR);
                if (class_q == CL_R) begin
                    alu_op = 2'b10;
                end else if (class_q == CL_IALU) begin
                    alu_op = 2'b11;
                end
            end
            case (state_q)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    ir_we        = mem_ready;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CL_STORE);
                    pc_we   = mem_ready && (class_q == CL_STORE);
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = (class_q == CL_JALR);
                    if (class_q == CL_LOAD) begin
                        wb_sel = 2'd1;
                    end else if (class_q == CL_JALR) begin
                        wb_sel = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_out     = state_q;
    assign halted        = (state_q == S_HALT);
    assign fault         = fault_q;
    assign fault_code    = code_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer. Each scenario queues per-cycle stimulus together
// with the outputs expected in that cycle, then replays the queue and compares
// the outputs at the falling edge.
module tb_mc_sequencer;

    localparam int TO = 6;
    localparam int CW = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'h7F;

    typedef struct packed {
        logic [2:0]    state;
        logic          pc_we;
        logic          pc_sel;
        logic          ir_we;
        logic          reg_we;
        logic [1:0]    wb_sel;
        logic          alu_src;
        logic [1:0]    alu_op;
        logic          mem_req;
        logic          mem_we;
        logic          fetch;
        logic          halted;
        logic          fault;
        logic [1:0]    code;
        logic [CW-1:0] ret;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic       inv;
        logic [6:0] op;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          alu_invalid;
    logic          mem_ready;
    logic          pc_we, pc_sel, ir_we, reg_we;
    logic [1:0]    wb_sel;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic          mem_req, mem_we, mem_is_fetch;
    logic [2:0]    state_out;
    logic          halted, fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] retired_count;

    obs_t obs;
    assign obs = {state_out, pc_we, pc_sel, ir_we, reg_we, wb_sel, alu_src, alu_op,
                  mem_req, mem_we, mem_is_fetch, halted, fault, fault_code, retired_count};

    mc_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_invalid(alu_invalid),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
        .reg_we(reg_we), .wb_sel(wb_sel), .alu_src(alu_src), .alu_op(alu_op),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
        .state_out(state_out), .halted(halted), .fault(fault),
        .fault_code(fault_code), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    stim_t         stim_q[$];
    obs_t          exp_q[$];
    obs_t          mask_q[$];
    logic [CW-1:0] ret;
    logic [6:0]    cur_op;
    int            n_vec = 0;
    int            n_bad = 0;

    // ---------------- expectation builders ----------------
    function automatic void push(input logic r, input logic rdy, input logic inv, input obs_t e, input obs_t m);
        stim_t s;
        s.rst = r; s.rdy = rdy; s.inv = inv; s.op = cur_op;
        stim_q.push_back(s);
        exp_q.push_back(e);
        mask_q.push_back(m);
    endfunction

    function automatic void p_fetch(input logic rdy);
        obs_t e = '0;
        e.state = 3'd0; e.mem_req = 1'b1; e.fetch = 1'b1; e.ir_we = rdy; e.ret = ret;
        push(1'b0, rdy, 1'b0, e, '1);
    endfunction

    function automatic void p_decode();
        obs_t e = '0;
        e.state = 3'd1; e.ret = ret;
        push(1'b0, 1'b0, 1'b0, e, '1);
    endfunction

    function automatic void p_exec(input logic src, input logic [1:0] aop, input logic inv);
        obs_t e = '0;
        e.state = 3'd2; e.alu_src = src; e.alu_op = aop; e.ret = ret;
        push(1'b0, 1'b0, inv, e, '1);
    endfunction

    function automatic void p_mem(input logic we, input logic rdy);
        obs_t e = '0;
        e.state = 3'd3; e.mem_req = 1'b1; e.mem_we = we; e.alu_src = 1'b1;
        e.pc_we = we & rdy; e.ret = ret;
        push(1'b0, rdy, 1'b0, e, '1);
        if (we && rdy) ret = ret + 1'b1;
    endfunction

    function automatic void p_wb(input logic [1:0] wbs, input logic pcs, input logic src, input logic [1:0] aop);
        obs_t e = '0;
        e.state = 3'd4; e.reg_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = wbs; e.pc_sel = pcs;
        e.alu_src = src; e.alu_op = aop; e.ret = ret;
        push(1'b0, 1'b0, 1'b0, e, '1);
        ret = ret + 1'b1;
    endfunction

    function automatic void p_halt(input logic f, input logic [1:0] c, input logic rdy);
        obs_t e = '0;
        e.state = 3'd5; e.halted = 1'b1; e.fault = f; e.code = c; e.ret = ret;
        push(1'b0, rdy, 1'b0, e, '1);
    endfunction

    // Reset cycle: only the state, the five strobes and the counter are pinned.
    function automatic void p_rst(input logic [2:0] st);
        obs_t e = '0;
        obs_t m = '0;
        e.state = st; e.ret = ret;
        m.state = '1; m.pc_we = 1'b1; m.ir_we = 1'b1; m.reg_we = 1'b1;
        m.mem_req = 1'b1; m.mem_we = 1'b1; m.ret = '1;
        push(1'b1, 1'b1, 1'b0, e, m);
        ret = '0;
    endfunction

    function automatic void p_alu(input logic [6:0] op, input logic src, input logic [1:0] aop,
                                  input logic [1:0] wbs, input logic pcs, input int fw);
        cur_op = op;
        for (int i = 0; i < fw; i++) p_fetch(1'b0);
        p_fetch(1'b1);
        p_decode();
        p_exec(src, aop, 1'b0);
        p_wb(wbs, pcs, src, aop);
    endfunction

    function automatic void p_memi(input logic we, input int fw, input int mw);
        cur_op = we ? OP_STORE : OP_LOAD;
        for (int i = 0; i < fw; i++) p_fetch(1'b0);
        p_fetch(1'b1);
        p_decode();
        p_exec(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < mw; i++) p_mem(we, 1'b0);
        p_mem(we, 1'b1);
        if (!we) p_wb(2'd1, 1'b0, 1'b1, 2'b00);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        stim_t s; obs_t e, m; int cyc = 0;
        p_rst(3'd0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL reset cyc %0d: got %h expected %h (mask %h)", cyc, obs, e, m);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_addi();
        stim_t s; obs_t e, m; int cyc = 0;
        p_alu(OP_IALU, 1'b1, 2'b11, 2'd0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL addi cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
        n_vec++;
        if (retired_count !== 4'd1) begin
            n_bad++;
            $display("FAIL addi_retired: got %0d expected 1", retired_count);
        end
    endtask

    task automatic test_load_store_jalr();
        stim_t s; obs_t e, m; int cyc = 0;
        p_memi(1'b0, 0, 2);
        p_memi(1'b1, 0, 0);
        p_memi(1'b1, 1, 1);
        p_alu(OP_JALR, 1'b1, 2'b00, 2'd2, 1'b1, 0);
        p_alu(OP_R, 1'b0, 2'b10, 2'd0, 1'b0, 2);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL ld_st_jalr cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_wait_limit();
        stim_t s; obs_t e, m; int cyc = 0;
        p_alu(OP_IALU, 1'b1, 2'b11, 2'd0, 1'b0, TO - 1);
        p_memi(1'b0, 0, TO - 1);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL wait_limit cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; obs_t e, m; int cyc = 0;
        for (int i = 0; i < 10; i++) p_alu(OP_IALU, 1'b1, 2'b11, 2'd0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_faults();
        stim_t s; obs_t e, m; int cyc = 0;
        cur_op = OP_IALU;
        p_fetch(1'b1); p_decode(); p_exec(1'b1, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) p_halt(1'b1, 2'd3, 1'b1);
        p_rst(3'd5);
        cur_op = OP_BAD;
        p_fetch(1'b1); p_decode();
        for (int i = 0; i < 20; i++) p_halt(1'b1, 2'd2, 1'b1);
        p_rst(3'd5);
        cur_op = OP_SYS;
        p_fetch(1'b1); p_decode();
        for (int i = 0; i < 3; i++) p_halt(1'b0, 2'd0, 1'b1);
        p_rst(3'd5);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL faults cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic test_timeout();
        stim_t s; obs_t e, m; int cyc = 0;
        cur_op = OP_IALU;
        for (int i = 0; i < TO; i++) p_fetch(1'b0);
        for (int i = 0; i < 3; i++) p_halt(1'b1, 2'd1, 1'b0);
        p_rst(3'd5);
        p_alu(OP_IALU, 1'b1, 2'b11, 2'd0, 1'b0, 0);
        cur_op = OP_STORE;
        p_fetch(1'b1); p_decode(); p_exec(1'b1, 2'b00, 1'b0);
        for (int i = 0; i < TO; i++) p_mem(1'b1, 1'b0);
        p_halt(1'b1, 2'd1, 1'b1);
        p_rst(3'd5);
        p_alu(OP_R, 1'b0, 2'b10, 2'd0, 1'b0, 0);
        cur_op = OP_LOAD;
        p_fetch(1'b1); p_decode(); p_exec(1'b1, 2'b00, 1'b0);
        p_mem(1'b0, 1'b0);
        p_rst(3'd3);
        p_alu(OP_IALU, 1'b1, 2'b11, 2'd0, 1'b0, 0);
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front(); m = mask_q.pop_front();
            rst = s.rst; mem_ready = s.rdy; alu_invalid = s.inv; opcode = s.op;
            @(negedge clk);
            n_vec++;
            if (((obs ^ e) & m) !== '0) begin
                n_bad++;
                $display("FAIL timeout cyc %0d: got %h expected %h", cyc, obs, e);
            end
            @(posedge clk); #1; cyc++;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; alu_invalid = 1'b0; opcode = 7'd0;
        ret = '0; cur_op = 7'd0;
        @(posedge clk); @(posedge clk); #1;
        test_reset();
        test_addi();
        test_load_store_jalr();
        test_wait_limit();
        test_back_to_back();
        test_faults();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control FSM that sequences the 64-bit RISC-V datapath through fetch, decode, execute, memory and writeback over several cycles. It replaces single-cycle combinational control so that instruction fetch and data access can share one handshaked, variable-latency memory port. It drives PC, IR, register-file and memory strobes plus the ALU/writeback selects. It also detects faults and counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, max cycles a wait state holds without mem_ready before faulting (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  instr[6:0] from IR; valid from DECODE onward
alu_invalid  in  1  ALU invalid-op flag
mem_ready  in  1  memory completes current request this cycle
pc_we  out  1  PC register load strobe
pc_sel  out  1  0=pc+4, 1=jalr target (alu_result & ~1)
ir_we  out  1  instruction register load strobe
reg_we  out  1  register-file write strobe
wb_sel  out  2  0=alu_result, 1=mem data, 2=pc+4
alu_src  out  1  0=rs2, 1=immediate
alu_op  out  2  00=add, 10=R-type funct decode, 11=I-type funct decode
mem_req  out  1  memory request
mem_we  out  1  memory write (valid with mem_req)
mem_is_fetch  out  1  request is instruction fetch (addr=pc)
state_out  out  3  current state encoding
halted  out  1  FSM in HALT
fault  out  1  halt was caused by a fault
fault_code  out  2  0=none/ecall, 1=mem timeout, 2=illegal opcode, 3=ALU invalid
retired_count  out  CNT_W  instructions completed

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Registered state; all strobes are Moore/Mealy decode of state, latched class, and mem_ready.
- Reset: state<=FETCH, class<=none, timeout counter<=0, retired_count<=0, fault<=0, fault_code<=0. While rst=1, every strobe (pc_we, ir_we, reg_we, mem_req, mem_we) is forced 0. Reset in any state, including mid-MEM or HALT, returns to FETCH on the next edge.
- FETCH: mem_req=1, mem_is_fetch=1, mem_we=0.
  - mem_ready=1: ir_we=1 in the same cycle, then ->DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify opcode and latch the class register.
  - Classes: 0110011 R, 0010011 IALU, 0000011 LOAD, 0100011 STORE, 1100111 JALR, 1110011 SYS.
  - SYS -> HALT, fault=0, code=0.
  - Any other opcode -> HALT, fault=1, code=2.
  - Otherwise -> EXEC.
- ALU selects are held constant in EXEC, MEM and WB:
  - alu_src = 1 for IALU, LOAD, STORE, JALR; 0 for R.
  - alu_op = 10 for R, 11 for IALU, 00 otherwise.
- EXEC:
  - alu_invalid=1 -> HALT, code=3, no writeback.
  - R, IALU, JALR -> WB.
  - LOAD, STORE -> MEM.
- MEM: mem_req=1, mem_is_fetch=0, mem_we=(class==STORE). On mem_ready:
  - LOAD -> WB.
  - STORE: pc_we=1, pc_sel=0, retired_count++, ->FETCH.
- WB: single cycle; reg_we=1, pc_we=1, retired_count++, ->FETCH.
  - wb_sel = 1 for LOAD, 2 for JALR, 0 otherwise.
  - pc_sel = 1 only for JALR.
- Timeout: counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states. When it reaches MEM_TIMEOUT with mem_ready still 0 -> HALT, code=1. mem_ready on the same cycle the limit is reached wins (completes normally).
- HALT:
  - All strobes are 0; halted=1; fault and fault_code hold.
  - Sticky until rst; retired_count frozen.
- Outside HALT, halted=0; fault and fault_code keep their reset value of 0.
- retired_count wraps modulo 2^CNT_W.
- Cycle counts with zero-wait memory: R/IALU/JALR = 4 cycles, LOAD = 5, STORE = 4. Each wait cycle adds 1.

Test Plan:
- Reset, then addi (0x00500093) with mem_ready=1 always -> state sequence 0,1,2,4; ir_we at cycle 0; reg_we=1, wb_sel=0, alu_src=1, alu_op=11 at cycle 3; retired_count=1 after edge 4.
- Load (opcode 0000011), mem_ready low 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, mem_we=0; WB with wb_sel=1; 7 cycles total; retired_count increments by 1.
- Store (opcode 0100011) -> MEM with mem_we=1; pc_we=1 on the ready cycle; reg_we never 1; next state FETCH.
- Jalr (opcode 1100111) -> WB with wb_sel=2, pc_sel=1, alu_op=00, alu_src=1.
- Faults:
  - opcode 0x7F -> HALT, fault=1, code=2; strobes stay 0 for 20 cycles.
  - ecall 0x00000073 -> HALT, fault=0, code=0.
  - alu_invalid=1 in EXEC -> code=3, reg_we never asserted.
- mem_ready held 0 in FETCH -> HALT with code=1 exactly MEM_TIMEOUT cycles after FETCH entry. Then rst asserted mid-MEM of a later load -> strobes 0 during rst, FETCH next cycle, retired_count=0.
